// File: rtl/acondicionador_botones_pkg.sv
// Shared constants for the push-button conditioning block: button indices,
// production timing, a short timing set for simulation, and a counter-width helper.
package acondicionador_botones_pkg;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_OK   = 2;
  localparam int NUM_BTN  = 3;

  // Production timing at 25 MHz: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat rate.
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_RATE     = 2500000;

  // Short timing set so simulations stay fast.
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_RATE     = 3;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_1b.sv
// One-button conditioner: 2-flop synchronizer, stability counter, debounced
// level (1 = pressed) and a registered one-cycle pulse on each accepted press.
module debounce_1b
  import acondicionador_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          s2_pressed;
  logic [CW-1:0] cnt;

  // The raw button is active-low; only the second synchronizer flop is used below.
  assign s2_pressed = ~s2;

  // Two-flop synchronizer, reset to the released (high) state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; pulse on press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2_pressed == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2_pressed;
        press <= s2_pressed;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Operator push-button conditioning: debounces up/down/ok, generates press
// pulses, auto-repeat on up/down while held, and locks out up/down when both are held.
module acondicionador_botones
  import acondicionador_botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic up,
  input  logic down,
  input  logic ok,
  output logic up_level,
  output logic down_level,
  output logic ok_level,
  output logic up_pulse,
  output logic down_pulse,
  output logic ok_pulse
);

  localparam int            TW        = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic               lock;

  // Repeat state for up (index 0) and down (index 1).
  logic [TW-1:0]      tmr [2];
  logic [1:0]         first;
  logic [1:0]         rep;

  assign raw[BTN_UP]   = up;
  assign raw[BTN_DOWN] = down;
  assign raw[BTN_OK]   = ok;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_1b #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign lock = level[BTN_UP] & level[BTN_DOWN];

  // Repeat timers: idle at 0 while released or locked out, first period REPEAT_DELAY,
  // then REPEAT_RATE; the timer reloads on every repeat so it can never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        tmr[i] <= '0;
      end
      first <= 2'b11;
      rep   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep[i] <= 1'b0;
        if ((REPEAT_EN == 0) || !level[i] || lock) begin
          tmr[i]   <= '0;
          first[i] <= 1'b1;
        end else if (tmr[i] == (first[i] ? DLY_LAST : RATE_LAST)) begin
          rep[i]   <= 1'b1;
          tmr[i]   <= '0;
          first[i] <= 1'b0;
        end else begin
          tmr[i] <= tmr[i] + TW'(1);
        end
      end
    end
  end

  // Gating with the current levels hides a repeat landing on the release edge
  // and suppresses up/down while the other direction is also held.
  assign up_pulse   = level[BTN_UP] & ~level[BTN_DOWN] & (press[BTN_UP] | rep[BTN_UP]);
  assign down_pulse = level[BTN_DOWN] & ~level[BTN_UP] & (press[BTN_DOWN] | rep[BTN_DOWN]);
  assign ok_pulse   = press[BTN_OK];

  assign up_level   = level[BTN_UP];
  assign down_level = level[BTN_DOWN];
  assign ok_level   = level[BTN_OK];

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones with the short simulation timing set.
module tb_acondicionador_botones;
  import acondicionador_botones_pkg::*;

  localparam int D    = SIM_DEBOUNCE_CYCLES;
  localparam int DLY  = SIM_REPEAT_DELAY;
  localparam int RATE = SIM_REPEAT_RATE;
  localparam int LAT  = D + 1;

  localparam int K_PULSE = 0;
  localparam int K_RISE  = 1;
  localparam int K_FALL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic       up_level, down_level, ok_level;
  logic       up_pulse, down_pulse, ok_pulse;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (SIM_REPEAT_DELAY),
    .REPEAT_RATE    (SIM_REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (btn_n[BTN_UP]),
    .down      (btn_n[BTN_DOWN]),
    .ok        (btn_n[BTN_OK]),
    .up_level  (up_level),
    .down_level(down_level),
    .ok_level  (ok_level),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .ok_pulse  (ok_pulse)
  );

  always #5 clk = ~clk;

  // Number of the most recent rising clock edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    int kind;
    int btn;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic void push_ev(input int e, input int k, input int b);
    ev_t x;
    x.edge_n = e;
    x.kind   = k;
    x.btn    = b;
    sb.push_back(x);
  endfunction

  // Clean press first sampled at edge k, released (first high sample) at edge k+n.
  function automatic void push_press(input int b, input int k, input int n);
    int p, f, e;
    p = k + LAT;
    f = k + n + LAT;
    push_ev(p, K_RISE, b);
    push_ev(p, K_PULSE, b);
    push_ev(f, K_FALL, b);
    if (b != BTN_OK) begin
      e = p + DLY;
      while (e < f) begin
        push_ev(e, K_PULSE, b);
        e += RATE;
      end
    end
  endfunction

  // Return at the falling edge just before edge e, so inputs set now are sampled at e.
  task automatic drive_at(input int e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    logic [5:0] o;
    o = {up_level, down_level, ok_level, up_pulse, down_pulse, ok_pulse};
    n_tests++;
    if (o !== 6'b0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b required=000000 at edge %0d", nm, o, cyc);
    end
  endtask

  task automatic match(input int k, input int b);
    int idx;
    idx = -1;
    n_tests++;
    foreach (sb[i]) begin
      if (idx < 0 && sb[i].edge_n == cyc && sb[i].kind == k && sb[i].btn == b) idx = i;
    end
    if (idx >= 0) begin
      sb.delete(idx);
    end else begin
      n_fail++;
      $display("FAIL event btn%0d kind%0d: seen at edge %0d, required no such event", b, k, cyc);
    end
  endtask

  // Monitor: every level change and every pulse must match a queued expectation.
  logic [2:0] prev_lvl = 3'b000;
  always @(negedge clk) begin
    logic [2:0] lv;
    logic [2:0] pl;
    lv = {ok_level, down_level, up_level};
    pl = {ok_pulse, down_pulse, up_pulse};
    if (!rst) begin
      prev_lvl = 3'b000;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (lv[b] !== prev_lvl[b]) match(lv[b] ? K_RISE : K_FALL, b);
        if (pl[b] === 1'b1) match(K_PULSE, b);
      end
      prev_lvl = lv;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tf;

    // Reset held with up pressed: everything stays low.
    rst   = 1'b0;
    btn_n = 3'b110;
    repeat (20) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst = 1'b1;
    t = cyc + 1;
    push_press(BTN_UP, t, 8);
    drive_at(t + 8);
    btn_n[BTN_UP] = 1'b1;
    drive_at(t + 8 + LAT + 5);

    // Clean ok press held 30 cycles.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_OK] = 1'b0;
    push_press(BTN_OK, t, 30);
    drive_at(t + 30);
    btn_n[BTN_OK] = 1'b1;
    drive_at(t + 30 + LAT + 5);

    // Bouncing up: three 2-cycle lows, then a real press.
    t = cyc + 2;
    for (int j = 0; j < 3; j++) begin
      drive_at(t + 4 * j);
      btn_n[BTN_UP] = 1'b0;
      drive_at(t + 4 * j + 2);
      btn_n[BTN_UP] = 1'b1;
    end
    tf = t + 12;
    drive_at(tf);
    btn_n[BTN_UP] = 1'b0;
    push_press(BTN_UP, tf, 8);
    drive_at(tf + 8);
    btn_n[BTN_UP] = 1'b1;
    drive_at(tf + 8 + LAT + 5);

    // Auto-repeat on down; level falls exactly where the next repeat would land.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_DOWN] = 1'b0;
    push_press(BTN_DOWN, t, 31);
    drive_at(t + 31);
    btn_n[BTN_DOWN] = 1'b1;
    drive_at(t + 31 + LAT + 8);

    // Lockout: up held, down joins, up released, down repeats after a full delay.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_UP] = 1'b0;
    push_ev(t + 5,  K_RISE,  BTN_UP);
    push_ev(t + 5,  K_PULSE, BTN_UP);
    push_ev(t + 12, K_RISE,  BTN_DOWN);
    push_ev(t + 27, K_FALL,  BTN_UP);
    push_ev(t + 37, K_PULSE, BTN_DOWN);
    push_ev(t + 40, K_PULSE, BTN_DOWN);
    push_ev(t + 41, K_FALL,  BTN_DOWN);
    drive_at(t + 7);
    btn_n[BTN_DOWN] = 1'b0;
    drive_at(t + 22);
    btn_n[BTN_UP] = 1'b1;
    drive_at(t + 36);
    btn_n[BTN_DOWN] = 1'b1;
    drive_at(t + 41 + 8);

    // 3-cycle glitch on ok: nothing happens.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_OK] = 1'b0;
    drive_at(t + 3);
    btn_n[BTN_OK] = 1'b1;
    drive_at(t + 20);

    // Simultaneous ok and up presses pulse together.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_OK] = 1'b0;
    btn_n[BTN_UP] = 1'b0;
    push_press(BTN_UP, t, 6);
    push_press(BTN_OK, t, 6);
    drive_at(t + 6);
    btn_n[BTN_OK] = 1'b1;
    btn_n[BTN_UP] = 1'b1;
    drive_at(t + 6 + LAT + 5);

    // Reset in the middle of an ok press, then full re-qualification.
    t = cyc + 2;
    drive_at(t);
    btn_n[BTN_OK] = 1'b0;
    push_ev(t + LAT, K_RISE,  BTN_OK);
    push_ev(t + LAT, K_PULSE, BTN_OK);
    drive_at(t + LAT + 3);
    #2 rst = 1'b0;
    #1 check_zero("reset_mid_press");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    t = cyc + 1;
    push_press(BTN_OK, t, 10);
    drive_at(t + 10);
    btn_n[BTN_OK] = 1'b1;
    drive_at(t + 10 + LAT + 5);

    // Any expectation still queued was never observed.
    drive_at(cyc + 10);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing btn%0d kind%0d: not seen, required at edge %0d", sb[i].btn, sb[i].kind, sb[i].edge_n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acondicionador_botones.md
Name: acondicionador_botones

Overview:
- Input conditioning stage for the operator push-buttons. It sits directly upstream of the calculator top level.
- Takes the raw active-low up/down/ok buttons and produces clean, debounced, active-high levels plus single-cycle press pulses.
- The downstream counters and the state counter consume only the pulses. This lets them use up/down/ok directly with no inversion.
- up/down get optional auto-repeat while held; ok never repeats.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz).
- REPEAT_EN, 1, 1 enables auto-repeat on up/down.
- REPEAT_DELAY, 12500000, cycles from the press pulse to the first repeat pulse (0.5 s).
- REPEAT_RATE, 2500000, cycles between subsequent repeat pulses (0.1 s).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- up, input, 1, raw button, active-low, asynchronous to clk.
- down, input, 1, raw button, active-low, asynchronous to clk.
- ok, input, 1, raw button, active-low, asynchronous to clk.
- up_level, output, 1, debounced up, 1 = pressed.
- down_level, output, 1, debounced down, 1 = pressed.
- ok_level, output, 1, debounced ok, 1 = pressed.
- up_pulse, output, 1, one-cycle pulse on press and on each auto-repeat.
- down_pulse, output, 1, one-cycle pulse on press and on each auto-repeat.
- ok_pulse, output, 1, one-cycle pulse on press only.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops = 1 (released).
  - Stable state = released.
  - All counters = 0.
  - All *_level and *_pulse outputs = 0.
- Reset mid-press: outputs drop immediately. After release of rst, a still-held button must re-qualify through the full debounce before pulsing.
- Synchronizer: 2-flop chain per button. All later logic uses only the second flop (s2).
- Debounce, per button:
  - Counter width = clog2(DEBOUNCE_CYCLES).
  - If s2 equals the stable state, counter <= 0.
  - Otherwise counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and s2 still differs: stable <= s2 and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and produces no change.
- Latency: for a clean press first sampled at edge k, *_level and the press pulse both go high at edge k+DEBOUNCE_CYCLES+1. Release is symmetric for *_level.
- Press pulse: registered, high for exactly one cycle on the released->pressed transition. No pulse on release.
- Auto-repeat (up/down, REPEAT_EN=1):
  - Repeat timer starts at the press pulse edge P.
  - Repeat pulses occur at P+REPEAT_DELAY, then every REPEAT_RATE cycles while *_level stays 1.
  - The edge at which *_level falls produces no pulse, and the timer clears.
- With REPEAT_EN=0, one pulse per press.
- Up/down lockout:
  - While up_level and down_level are both 1, up_pulse and down_pulse are forced 0 and both repeat timers are held at 0.
  - A button that becomes pressed while the other is already held gives no press pulse.
  - When one is released, the still-held button's timer restarts. Its first repeat pulse comes REPEAT_DELAY cycles later, with no immediate pulse.
- ok is independent of up/down. Simultaneous ok and up presses both pulse in the same cycle.
- Timers saturate-safe: the repeat counter reloads and never wraps into a spurious pulse.

Decomposition:
- Shared package holds:
  - Button index constants BTN_UP=0, BTN_DOWN=1, BTN_OK=2.
  - Default timing constants.
  - A simulation timing set with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Sub-module debounce_1b: 2-flop synchronizer, debounce counter, stable register and registered press pulse. Instantiated three times.
- Repeat timers and lockout logic live in the top of this block.

Test Plan (sim parameters 4/10/3):
- Reset: hold rst=0 with up=0 for 20 cycles, then release -> all outputs 0 during reset; up_level/up_pulse appear 5 edges after release, one pulse only.
- Clean ok press: ok falls, first sampled at edge 10, held 30 cycles -> ok_level rises and ok_pulse is high for one cycle at edge 15; no further pulses; ok_level falls 5 edges after release.
- Bounce: up toggles low/high every 2 cycles for 12 cycles, then stays low -> no pulse during bouncing; exactly one up_pulse 5 edges after the final fall.
- Auto-repeat: down held 30 cycles after its pulse at edge P -> pulses at P, P+10, P+13, P+16, ..., P+28; none after release.
- Lockout: up held, then down pressed and qualified, held 15 cycles, then up released -> no up/down pulses while both are held; first down_pulse 10 cycles after up_level falls.
- Glitch: a 3-cycle low glitch on ok -> ok_level and ok_pulse stay 0 throughout.
